// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requester blocks and the shared-resource arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until they are done with the resource.
interface rr_arbiter4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter: 4 requesters share one one-hot select, with optional hold timeout.
// Latency: req sampled in IDLE gives a registered grant one cycle later; one dead cycle after every release.
// Backpressure: en=0 blocks new grants only; a holder keeps its grant until req drops or MAX_HOLD expires.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave arb
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state;
    logic [1:0]        idx_q;
    logic [1:0]        last_q;
    logic              vld_q;
    logic              tmo_q;
    logic [HOLD_W-1:0] hold_cnt;

    logic [1:0]        sel;
    logic [1:0]        cand;
    logic              found;
    logic              hold_exp;

    // Search starts just after the last winner and wraps; k=4 lands back on last itself.
    always_comb begin
        sel   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && arb.req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign hold_exp = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= 2'd0;
            last_q   <= 2'd3;
            vld_q    <= 1'b0;
            tmo_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            tmo_q <= 1'b0;
            if (state == IDLE) begin
                if (arb.en && found) begin
                    state    <= GRANT;
                    idx_q    <= sel;
                    last_q   <= sel;
                    vld_q    <= 1'b1;
                    hold_cnt <= HOLD_W'(1);
                end
            end else begin
                // Release always passes through IDLE, giving downstream a dead cycle.
                if (!arb.req[idx_q]) begin
                    state    <= IDLE;
                    vld_q    <= 1'b0;
                    hold_cnt <= '0;
                end else if (hold_exp) begin
                    state    <= IDLE;
                    vld_q    <= 1'b0;
                    tmo_q    <= 1'b1;
                    hold_cnt <= '0;
                end else if (hold_cnt != {HOLD_W{1'b1}}) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

    assign arb.grant       = vld_q ? (4'b0001 << idx_q) : 4'b0000;
    assign arb.grant_idx   = idx_q;
    assign arb.grant_valid = vld_q;
    assign arb.timeout     = tmo_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboarded directed test of rr_arbiter4 with MAX_HOLD=8 and MAX_HOLD=0 instances.
module tb_rr_arbiter4;
    logic clk;
    logic rst_n;

    rr_arbiter4_if a8 ();
    rr_arbiter4_if a0 ();

    rr_arbiter4 #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .arb(a8));
    rr_arbiter4 #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .arb(a0));

    // Expected outputs after the next rising edge; which=1 selects the MAX_HOLD=0 instance.
    typedef struct packed {
        logic       which;
        logic [3:0] g;
        logic [1:0] idx;
        logic       t;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got {grant,idx,valid,timeout}=%b required %b at %0t", nm, act, expv, $time);
    endtask

    function automatic logic [7:0] obs(input logic which);
        if (which) return {a0.grant, a0.grant_idx, a0.grant_valid, a0.timeout};
        return {a8.grant, a8.grant_idx, a8.grant_valid, a8.timeout};
    endfunction

    task automatic drive_push(input logic which, input logic e, input logic [3:0] r,
                              input logic [3:0] eg, input logic [1:0] ei, input logic et,
                              input string nm);
        exp_t x;
        if (which) begin a0.en = e; a0.req = r; end
        else       begin a8.en = e; a8.req = r; end
        x.which = which; x.g = eg; x.idx = ei; x.t = et;
        exp_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic step(input logic which, input logic e, input logic [3:0] r,
                        input logic [3:0] eg, input logic [1:0] ei, input logic et,
                        input string nm);
        @(negedge clk);
        drive_push(which, e, r, eg, ei, et, nm);
    endtask

    // Monitor: compare every pending expectation just after the edge it belongs to.
    initial begin
        exp_t  x;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n = nm_q.pop_front();
                chk(n, obs(x.which), {x.g, x.idx, (x.g != 4'b0000), x.t});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [3:0] ORDER_G [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [1:0] ORDER_I [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst_n = 1'b0;
        a8.en = 1'b0; a8.req = 4'b0000;
        a0.en = 1'b0; a0.req = 4'b0000;
        #12;
        chk("reset8", obs(1'b0), 8'b0000_00_0_0);
        chk("reset0", obs(1'b1), 8'b0000_00_0_0);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, "idle_noreq");

        // All four requesting with MAX_HOLD=8: 8 granted cycles, then a timeout/dead cycle.
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++)
                step(0, 1, 4'b1111, ORDER_G[g], ORDER_I[g], 0, "rr_hold");
            step(0, 1, 4'b1111, 4'b0000, ORDER_I[g], 1, "rr_timeout");
        end
        step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, "rr_drop");

        // Requester 2 holds 3 cycles then releases without a timeout.
        for (int c = 0; c < 3; c++)
            step(0, 1, 4'b0100, 4'b0100, 2'd2, 0, "short_hold");
        step(0, 1, 4'b0000, 4'b0000, 2'd2, 0, "short_release");
        step(0, 1, 4'b0000, 4'b0000, 2'd2, 0, "short_idle");

        // Serve requester 1, then 0 and 1 both ask: search from 2 wraps to 0.
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 0, "serve1");
        step(0, 1, 4'b0000, 4'b0000, 2'd1, 0, "serve1_rel");
        step(0, 1, 4'b0011, 4'b0001, 2'd0, 0, "wrap_to0");
        step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, "wrap_rel");

        // Non-granted request bits are ignored while a grant is held.
        step(0, 1, 4'b0100, 4'b0100, 2'd2, 0, "ign_grant");
        step(0, 1, 4'b1100, 4'b0100, 2'd2, 0, "ign_add3");
        step(0, 1, 4'b0101, 4'b0100, 2'd2, 0, "ign_swap");
        step(0, 1, 4'b0000, 4'b0000, 2'd2, 0, "ign_rel");

        // en gating: blocks new grants, has no effect on a held grant.
        for (int c = 0; c < 5; c++)
            step(0, 0, 4'b0001, 4'b0000, 2'd2, 0, "en_blocked");
        step(0, 1, 4'b0001, 4'b0001, 2'd0, 0, "en_grant");
        step(0, 0, 4'b0001, 4'b0001, 2'd0, 0, "en_off_hold");
        step(0, 0, 4'b0001, 4'b0001, 2'd0, 0, "en_off_hold");
        step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, "en_off_rel");

        // Asynchronous reset in the middle of a grant to requester 1.
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 0, "pre_rst_grant");
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 0, "pre_rst_hold");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", obs(1'b0), 8'b0000_00_0_0);
        a8.req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        drive_push(0, 1, 4'b0110, 4'b0010, 2'd1, 0, "post_rst_grant");
        step(0, 1, 4'b0000, 4'b0000, 2'd1, 0, "post_rst_rel");

        // MAX_HOLD=0 instance: requester 3 holds for 40 cycles with no timeout.
        for (int c = 0; c < 40; c++)
            step(1, 1, 4'b1000, 4'b1000, 2'd3, 0, "nohold_40");
        step(1, 1, 4'b0000, 4'b0000, 2'd3, 0, "nohold_rel");

        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        done = 1;
        $finish;
    end
endmodule
